// File: rtl/background_fb.sv
// Double-buffered background frame buffer: front bank feeds the display,
// back bank takes renderer writes or a hardware colour fill.
module background_fb #(
    parameter int WIDTH         = 320,
    parameter int HEIGHT        = 240,
    parameter int NUMBER_COLORS = 10,
    localparam int CW           = $clog2(NUMBER_COLORS) + 1,
    localparam int XW           = $clog2(WIDTH),
    localparam int YW           = $clog2(HEIGHT),
    localparam int DEPTH        = WIDTH * HEIGHT,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    output logic [CW-1:0] dout,
    input  logic [CW-1:0] din,
    input  logic [AW-1:0] waddr,
    input  logic          we,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_color,
    output logic          clear_busy,
    input  logic          swap_req,
    input  logic          vsync,
    output logic          swap_pending,
    output logic          front_sel
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [CW-1:0] color, color_n;

    logic [CW-1:0] mem0 [DEPTH];
    logic [CW-1:0] mem1 [DEPTH];

    logic          in_range;
    logic [AW-1:0] raddr;
    logic [CW-1:0] rd0, rd1;
    logic          sel_q, ok_q;

    logic          wen;
    logic [AW-1:0] wa;
    logic [CW-1:0] wd;
    logic          do_swap;

    // Read side: out-of-frame coordinates are clamped to 0 and masked.
    assign in_range = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    assign raddr    = in_range ? AW'(int'(y) + HEIGHT * int'(x)) : '0;

    always_ff @(posedge clk) begin
        rd0 <= mem0[raddr];
        rd1 <= mem1[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= 1'b0;
            ok_q  <= 1'b0;
        end else begin
            sel_q <= front_sel;
            ok_q  <= in_range;
        end
    end

    assign dout = ok_q ? (sel_q ? rd1 : rd0) : '0;

    // Clear engine owns the back-bank port; renderer writes are dropped.
    assign clear_busy = (state == CLEAR);

    always_comb begin
        wen = 1'b0;
        wa  = waddr;
        wd  = din;
        if (clear_busy) begin
            wen = 1'b1;
            wa  = cnt;
            wd  = color;
        end else if (we && (int'(waddr) < DEPTH)) begin
            wen = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wen && front_sel)
            mem0[wa] <= wd;
        if (wen && !front_sel)
            mem1[wa] <= wd;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        color_n = color;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    color_n = clear_color;
                end
            end
            CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            color <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            color <= color_n;
        end
    end

    // Swap only at a vsync where no fill is running; a new request wins.
    assign do_swap = vsync && swap_pending && !clear_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
        end else begin
            if (do_swap)
                front_sel <= ~front_sel;
            swap_pending <= swap_req || (swap_pending && !do_swap);
        end
    end

endmodule

// File: tb/tb_background_fb.sv
// Bench for background_fb: behavioural frame-buffer model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_background_fb;

    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int NC     = 10;
    localparam int CW     = $clog2(NC) + 1;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);
    localparam int DEPTH  = WIDTH * HEIGHT;
    localparam int AW     = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] dout;
    logic [CW-1:0] din;
    logic [AW-1:0] waddr;
    logic          we;
    logic          clear_req;
    logic [CW-1:0] clear_color;
    logic          clear_busy;
    logic          swap_req;
    logic          vsync;
    logic          swap_pending;
    logic          front_sel;

    int checks = 0;
    int errors = 0;

    background_fb #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUMBER_COLORS(NC)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .dout(dout),
        .din(din), .waddr(waddr), .we(we),
        .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .swap_req(swap_req), .vsync(vsync),
        .swap_pending(swap_pending), .front_sel(front_sel)
    );

    always #5 clk = ~clk;

    // Model: bank contents as ints, -1 meaning never written.
    int m_mem [2][DEPTH];
    int m_front, m_pending, m_left, m_col, m_dout;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                m_mem[b][a] = -1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_front = 0; m_pending = 0; m_left = 0; m_col = 0; m_dout = 0;
        end else begin
            int  busy_old, pend_old, front_old;
            busy_old  = (m_left > 0);
            pend_old  = m_pending;
            front_old = m_front;
            if (int'(x) < WIDTH && int'(y) < HEIGHT)
                m_dout = m_mem[front_old][int'(y) + HEIGHT * int'(x)];
            else
                m_dout = 0;
            if (busy_old) begin
                m_mem[1 - front_old][DEPTH - m_left] = m_col;
                m_left--;
            end else if (we && int'(waddr) < DEPTH) begin
                m_mem[1 - front_old][int'(waddr)] = int'(din);
            end
            if (!busy_old && clear_req) begin
                m_left = DEPTH;
                m_col  = int'(clear_color);
            end
            if (vsync && pend_old && !busy_old) begin
                m_front   = 1 - front_old;
                m_pending = 0;
            end
            if (swap_req) m_pending = 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("model_busy", int'(clear_busy), int'(m_left > 0));
            check("model_pending", int'(swap_pending), m_pending);
            check("model_front", int'(front_sel), m_front);
            if (m_dout >= 0) check("model_dout", int'(dout), m_dout);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic read_px(input int cx, input int cy, input int exp, input string name);
        x = XW'(cx);
        y = YW'(cy);
        step();
        check(name, int'(dout), exp);
    endtask

    initial begin
        int n;
        int xs [7] = '{0, 0, 1, 319, 0, 319, 160};
        int ys [7] = '{0, 5, 1, 239, 239, 0, 120};
        rst_n = 1'b0; x = '0; y = '0; din = '0; waddr = '0; we = 1'b0;
        clear_req = 1'b0; clear_color = '0; swap_req = 1'b0; vsync = 1'b0;
        repeat (3) step();
        check("rst_dout", int'(dout), 0);
        check("rst_front", int'(front_sel), 0);
        check("rst_pending", int'(swap_pending), 0);
        check("rst_busy", int'(clear_busy), 0);
        rst_n = 1'b1;
        step();

        // Write into back bank 1, swap it in, read it out.
        we = 1'b1; waddr = AW'(241); din = CW'(7);
        step();
        we = 1'b0; swap_req = 1'b1;
        step();
        swap_req = 1'b0; vsync = 1'b1;
        step();
        vsync = 1'b0;
        check("t1_front", int'(front_sel), 1);
        check("t1_pending", int'(swap_pending), 0);
        read_px(1, 1, 7, "t1_dout");

        // Out-of-frame reads and out-of-range write.
        read_px(320, 0, 0, "t2_x_oob");
        read_px(0, 240, 0, "t2_y_oob");
        we = 1'b1; waddr = AW'(DEPTH); din = CW'(5);
        step();
        we = 1'b0;
        read_px(1, 1, 7, "t2_unchanged");

        // Clear bank 0 with colour 3, with noise during the fill.
        clear_color = CW'(3); clear_req = 1'b1;
        step();
        clear_req = 1'b0; clear_color = '0;
        n = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            if (!clear_busy) break;
            n++;
            if (i == 10) begin we = 1'b1; waddr = AW'(5); din = CW'(9); end
            if (i == 12) we = 1'b0;
            if (i == 20) begin clear_req = 1'b1; clear_color = CW'(8); end
            if (i == 21) begin clear_req = 1'b0; clear_color = '0; end
            if (i == 100) swap_req = 1'b1;
            if (i == 101) swap_req = 1'b0;
            if (i == 200) vsync = 1'b1;
            if (i == 201) vsync = 1'b0;
            if (i == 203) begin
                check("t4_front_held", int'(front_sel), 1);
                check("t4_pending_held", int'(swap_pending), 1);
            end
            step();
        end
        check("t3_busy_cycles", n, DEPTH);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check("t4_front_swapped", int'(front_sel), 0);
        check("t4_pending_clr", int'(swap_pending), 0);
        for (int k = 0; k < 7; k++)
            read_px(xs[k], ys[k], 3, "t3_fill");

        // swap_req and vsync together: no swap until next vsync.
        swap_req = 1'b1; vsync = 1'b1;
        step();
        swap_req = 1'b0; vsync = 1'b0;
        check("t5_front_same", int'(front_sel), 0);
        check("t5_pending_set", int'(swap_pending), 1);
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check("t5_front_swap", int'(front_sel), 1);
        check("t5_pending_clr", int'(swap_pending), 0);

        // Reset in the middle of a fill of bank 0.
        x = XW'(1); y = YW'(1);
        clear_color = CW'(2); clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("t6_dout_pre", int'(dout), 7);
        repeat (1000) step();
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_async", int'(clear_busy), 0);
        check("t6_dout_async", int'(dout), 0);
        check("t6_front_async", int'(front_sel), 0);
        check("t6_pending_async", int'(swap_pending), 0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        read_px(1, 1, 2, "t6_partial_fill");
        read_px(319, 239, 3, "t6_untouched");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
